// File: rtl/tri_debounce_pkg.sv
// Shared constants and types for the three-channel input debouncer.
package tri_debounce_pkg;

  localparam int NCH               = 3;
  localparam int CNT_W_DEF         = 16;
  localparam int STABLE_CYCLES_DEF = 50000;

  typedef logic [NCH-1:0] chan_vec_t;

endpackage

// File: rtl/debounce_chan.sv
// One debounce channel: 2-flop synchroniser followed by a stability counter
// that commits a new output level after STABLE_CYCLES consecutive disagreements.
module debounce_chan
  import tri_debounce_pkg::*;
#(
  parameter int   CNT_W         = CNT_W_DEF,
  parameter int   STABLE_CYCLES = STABLE_CYCLES_DEF,
  parameter logic RESET_VAL     = 1'b0
) (
  input  logic CLK,
  input  logic RST,
  input  logic raw_in,
  output logic out,
  output logic chg
);

  localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(STABLE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             out_q, out_d;
  logic             chg_q, chg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counter only runs while the synchronised input disagrees with the output;
  // any agreement (including a glitch returning) discards accumulated progress.
  always_comb begin
    sync1_d = raw_in;
    sync2_d = sync1_q;
    out_d   = out_q;
    chg_d   = 1'b0;
    cnt_d   = '0;
    if (sync2_q != out_q) begin
      if (cnt_q == TERM_CNT) begin
        out_d = sync2_q;
        chg_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1_q <= RESET_VAL;
      sync2_q <= RESET_VAL;
      out_q   <= RESET_VAL;
      chg_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      out_q   <= out_d;
      chg_q   <= chg_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out = out_q;
  assign chg = chg_q;

endmodule

// File: rtl/tri_input_debouncer.sv
// Three independent debounce channels feeding clean A/B/C plus change strobes.
// Define TRI_DEBOUNCE_EDGE_EN to add the RISE/FALL edge-strobe ports.
module tri_input_debouncer
  import tri_debounce_pkg::*;
#(
  parameter int        CNT_W         = CNT_W_DEF,
  parameter int        STABLE_CYCLES = STABLE_CYCLES_DEF,
  parameter chan_vec_t RESET_VAL     = '0
) (
  input  logic      CLK,
  input  logic      RST,
  input  chan_vec_t RAW,
  output logic      A,
  output logic      B,
  output logic      C,
  output chan_vec_t CHG
`ifdef TRI_DEBOUNCE_EDGE_EN
  ,
  output chan_vec_t RISE,
  output chan_vec_t FALL
`endif
);

  chan_vec_t out_vec;
  chan_vec_t chg_vec;

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    debounce_chan #(
      .CNT_W         (CNT_W),
      .STABLE_CYCLES (STABLE_CYCLES),
      .RESET_VAL     (RESET_VAL[i])
    ) u_chan (
      .CLK    (CLK),
      .RST    (RST),
      .raw_in (RAW[i]),
      .out    (out_vec[i]),
      .chg    (chg_vec[i])
    );
  end

  assign A   = out_vec[0];
  assign B   = out_vec[1];
  assign C   = out_vec[2];
  assign CHG = chg_vec;

`ifdef TRI_DEBOUNCE_EDGE_EN
  // Built only from channel flops, so edges line up with CHG and carry no RAW path.
  assign RISE = chg_vec & out_vec;
  assign FALL = chg_vec & ~out_vec;
`endif

endmodule

// File: tb/tb_tri_input_debouncer.sv
// Scoreboard bench: a windowed reference model predicts outputs each edge,
// a monitor compares them against the debouncer on the falling edge.
module tb_tri_input_debouncer;

  localparam int         S  = 4;
  localparam logic [2:0] RV = 3'b000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] raw = 3'b111;
  logic       a, b, c;
  logic [2:0] chg;
`ifdef TRI_DEBOUNCE_EDGE_EN
  logic [2:0] rise, fall;
`endif

  always #5 clk = ~clk;

  tri_input_debouncer #(
    .CNT_W         (4),
    .STABLE_CYCLES (S),
    .RESET_VAL     (RV)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .RAW (raw),
    .A   (a),
    .B   (b),
    .C   (c),
    .CHG (chg)
`ifdef TRI_DEBOUNCE_EDGE_EN
    ,
    .RISE (rise),
    .FALL (fall)
`endif
  );

  typedef struct packed {
    logic [2:0] chg;
    logic [2:0] out;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference: an input level is "seen" two edges after it is sampled (reset
  // value before that); the output flips once the last S seen values since
  // reset all disagree with it.
  logic [2:0] m_out = RV;
  logic [2:0] samples[$];
  logic [2:0] seen[$];

  always @(posedge clk) begin
    logic [2:0] ev;
    logic [2:0] mchg;
    logic       all_diff;
    exp_t       e;
    mchg = 3'b000;
    if (rst) begin
      m_out = RV;
      samples.delete();
      samples.push_back(RV);
      samples.push_back(RV);
      seen.delete();
    end else begin
      samples.push_back(raw);
      ev = samples[samples.size()-3];
      if (samples.size() > 3) void'(samples.pop_front());
      seen.push_back(ev);
      if (seen.size() > S) void'(seen.pop_front());
      for (int i = 0; i < 3; i++) begin
        all_diff = (seen.size() == S);
        foreach (seen[j]) if (seen[j][i] == m_out[i]) all_diff = 1'b0;
        mchg[i] = all_diff;
      end
      m_out = m_out ^ mchg;
    end
    e.chg = mchg;
    e.out = m_out;
    exp_q.push_back(e);
  end

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({chg, c, b, a} !== {e.chg, e.out} || (a & b & c) !== (&e.out)) begin
        errors++;
        $display("FAIL outputs t=%0t got chg=%b cba=%b and3=%b expected chg=%b cba=%b and3=%b",
                 $time, chg, {c, b, a}, a & b & c, e.chg, e.out, &e.out);
      end
`ifdef TRI_DEBOUNCE_EDGE_EN
      checks++;
      if (rise !== (e.chg & e.out) || fall !== (e.chg & ~e.out)) begin
        errors++;
        $display("FAIL edges t=%0t got rise=%b fall=%b expected rise=%b fall=%b",
                 $time, rise, fall, e.chg & e.out, e.chg & ~e.out);
      end
`endif
    end
  end

  task automatic drive(input logic [2:0] r, input logic rs, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      raw = r;
      rst = rs;
    end
  endtask

  initial begin
    int len;
    logic [2:0] r;
    // Reset held with inputs high, then release
    drive(3'b111, 1'b1, 1);
    drive(3'b111, 1'b0, 10);
    // Single channel rise after returning low
    drive(3'b000, 1'b0, 10);
    drive(3'b001, 1'b0, 10);
    // Short pulse on B must be filtered
    drive(3'b011, 1'b0, 3);
    drive(3'b001, 1'b0, 20);
    // All channels together
    drive(3'b000, 1'b0, 10);
    drive(3'b111, 1'b0, 10);
    drive(3'b000, 1'b0, 10);
    // Reset in the middle of counting on C
    drive(3'b100, 1'b0, 2);
    drive(3'b100, 1'b1, 2);
    drive(3'b100, 1'b0, 12);
    // Long toggles on A
    drive(3'b101, 1'b0, 10);
    drive(3'b100, 1'b0, 10);
    // Random runs with occasional reset
    for (int k = 0; k < 400; k++) begin
      r   = 3'($urandom);
      len = $urandom_range(1, 8);
      if ($urandom_range(0, 40) == 0) drive(r, 1'b1, $urandom_range(1, 2));
      drive(r, 1'b0, len);
    end
    drive(raw, 1'b0, 12);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
